reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL: parameter CH_NUM, default 4, number of reset output channels (legal 1..16).
REQ-002 SHALL: parameter FILTER_LEN, default 8, clean-high cycles required before channel 0 releases (legal 1..255).
REQ-003 SHALL: parameter STAGE_GAP, default 16, cycles between successive channel releases (legal 1..255).
REQ-004 SHALL: sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL: p_rst_n  input  1  system port reset; asynchronous, active-low.
REQ-006 SHALL: soft_rst_req  input  1  synchronous software reset request, active-high, level or pulse.
REQ-007 SHALL: sys_rst_n  output  CH_NUM  per-channel reset, active-low, registered; bit 0 releases first.
REQ-008 SHALL: rst_done  output  1  high when every channel is released.

Function
REQ-009 SHALL: assert all sys_rst_n bits and clear rst_done asynchronously, with no clock, while p_rst_n is low.
REQ-010 SHALL: synchronise p_rst_n deassertion through a 2-flop chain; both flops are async-cleared by p_rst_n.
REQ-011 SHALL: use FSM states HOLD, STAGE, DONE; one counter of width clog2(max(FILTER_LEN,STAGE_GAP)+1); one channel index.
REQ-012 SHALL: HOLD: all outputs low; counter counts cycles with synchroniser output high; at count FILTER_LEN, release bit 0 and go to STAGE with index 1.
REQ-013 SHALL: STAGE: every STAGE_GAP cycles, release bit[index] and increment index; on releasing bit CH_NUM-1, go to DONE.
REQ-014 SHALL: if CH_NUM=1, go from HOLD straight to DONE when bit 0 releases.
REQ-015 SHALL: DONE: all bits high and rst_done high, held until p_rst_n is low or a soft reset is accepted.
REQ-016 SHALL: timing: T0 = first edge at which sync flop 1 captures high; bit k rises at edge T0+1+FILTER_LEN+k*STAGE_GAP; rst_done rises on the same edge as bit CH_NUM-1.
REQ-017 SHALL: released bits stay high and unreleased bits stay low during the sequence (monotonic release, no glitches).
REQ-018 SHALL: a low pulse on p_rst_n of any width, in any state, restarts the full sequence from HOLD with the counter cleared.
REQ-019 SHALL: soft reset accepted at edge S, in any state: all bits low and rst_done low after edge S; state HOLD, counter cleared; bit k rises at edge S+FILTER_LEN+k*STAGE_GAP.
REQ-020 SHALL: while soft_rst_req is held high, keep the block in HOLD with the counter cleared; counting starts on the first edge with the request low.
REQ-021 SHALL: p_rst_n low takes priority over soft_rst_req.
REQ-022 SHALL: the counter saturates and never wraps; the index never exceeds CH_NUM-1.

Reset
REQ-023 SHALL: reset values: sys_rst_n = all zeros, rst_done = 0, state = HOLD, counter = 0, index = 0, sync flops = 0.
REQ-024 SHALL: reset assertion is asynchronous and reset deassertion is synchronous to sys_clk (REQ-010).

Configuration
REQ-025 SHALL: with macro RESET_SEQ_SOFT_EN defined, soft_rst_req behaves per REQ-019 to REQ-021.
REQ-026 SHALL: with RESET_SEQ_SOFT_EN undefined, soft_rst_req is still a port but is ignored; only p_rst_n restarts the sequence.

Verification
REQ-027 SHALL: power-up, CH_NUM=4, FILTER_LEN=8, STAGE_GAP=16, p_rst_n rises before T0 -> bits 0..3 rise at T0+9, T0+25, T0+41, T0+57; rst_done rises at T0+57.
REQ-028 SHALL: 2 ns low glitch on p_rst_n at T0+30 (between clock edges) -> sys_rst_n = 4'b0000 within the glitch, before any edge; sequence restarts, bit 0 rises 9 edges after the new T0.
REQ-029 SHALL: RESET_SEQ_SOFT_EN defined, DONE state, 1-cycle soft_rst_req at edge S -> 4'b0000 after S; bits rise at S+8, S+24, S+40, S+56.
REQ-030 SHALL: RESET_SEQ_SOFT_EN defined, soft_rst_req held high 20 cycles during STAGE -> outputs stay 0 during the hold; bit 0 rises 8 edges after the request drops.
REQ-031 SHALL: RESET_SEQ_SOFT_EN undefined, soft_rst_req pulsed in DONE -> sys_rst_n stays 4'b1111 and rst_done stays 1.
REQ-032 SHALL: CH_NUM=1, FILTER_LEN=1, STAGE_GAP=1 -> bit 0 and rst_done rise at T0+2; no STAGE state entered.

Source files
------------

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq -- staged reset release sequencer
//
// Holds CH_NUM active-low reset outputs low while the port reset is asserted,
// then releases them one at a time once the synchronised port reset has been
// clean-high for FILTER_LEN cycles. Each later channel follows STAGE_GAP
// cycles after the one before it. rst_done rises on the same edge as the last
// channel.
//
// Parameters
//   CH_NUM      number of reset output channels (1..16)
//   FILTER_LEN  clean-high cycles before channel 0 releases (1..255)
//   STAGE_GAP   cycles between successive channel releases (1..255)
//
// Ports
//   sys_clk       in   system clock, rising edge
//   p_rst_n       in   port reset, async assert, active low
//   soft_rst_req  in   software reset request, sync, active high
//   sys_rst_n     out  [CH_NUM] per-channel reset, active low, registered
//   rst_done      out  every channel released
//
// Build option
//   RESET_SEQ_SOFT_EN  when defined, soft_rst_req restarts the sequence.
//                      When undefined, the port exists but is ignored.
// -----------------------------------------------------------------------------

// One output channel. It stays low until a release strobe arrives and then
// stays high. Only a soft clear or the port reset takes it low again, so a
// channel can never glitch during the sequence.
module reset_seq_ch (
  input  logic sys_clk,
  input  logic p_rst_n,
  input  logic clr_i,
  input  logic rel_i,
  output logic rst_n_o
);

  logic rst_n_q, rst_n_d;

  always_comb begin
    rst_n_d = rst_n_q | rel_i;
    if (clr_i) rst_n_d = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge p_rst_n) begin
    if (!p_rst_n) rst_n_q <= 1'b0;
    else          rst_n_q <= rst_n_d;
  end

  assign rst_n_o = rst_n_q;

endmodule

module reset_seq #(
  parameter int CH_NUM     = 4,
  parameter int FILTER_LEN = 8,
  parameter int STAGE_GAP  = 16
) (
  input  logic              sys_clk,
  input  logic              p_rst_n,
  input  logic              soft_rst_req,
  output logic [CH_NUM-1:0] sys_rst_n,
  output logic              rst_done
);

  localparam int CNT_MAX = (FILTER_LEN > STAGE_GAP) ? FILTER_LEN : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  // The compare points are one below the lengths. The output flops take the
  // release on the edge where the count would reach the length.
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic [1:0]        sync_q, sync_d;
  logic [CH_NUM-1:0] rel;
  logic              soft_go;
  logic              soft_clr;

  // ---------------------------------------------------------------------------
  // Soft reset gating
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_SOFT_EN
  assign soft_go = soft_rst_req;
`else
  logic unused_soft;
  assign unused_soft = soft_rst_req;
  assign soft_go     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Port reset deassertion synchroniser. Both flops clear asynchronously, so
  // any low pulse on p_rst_n, however short, restarts the filter.
  // ---------------------------------------------------------------------------
  assign sync_d = {sync_q[0], 1'b1};

  always_ff @(posedge sys_clk or negedge p_rst_n) begin
    if (!p_rst_n) sync_q <= 2'b00;
    else          sync_q <= sync_d;
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next state, counter, index and release strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    done_d   = done_q;
    rel      = '0;
    soft_clr = 1'b0;

    if (soft_go) begin
      // While the request is held, the block stays parked in HOLD with the
      // count at zero. Counting resumes on the first edge where the request
      // is low.
      state_d  = HOLD;
      cnt_d    = '0;
      idx_d    = '0;
      done_d   = 1'b0;
      soft_clr = 1'b1;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!sync_q[1]) begin
            cnt_d = '0;
          end else if (cnt_q == FILT_LAST) begin
            rel[0] = 1'b1;
            cnt_d  = '0;
            if (CH_NUM == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = STAGE;
              idx_d   = IDX_W'(1);
            end
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        STAGE: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < CH_NUM; i++) begin
              if (idx_q == IDX_W'(i)) rel[i] = 1'b1;
            end
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          rel    = '1;
          done_d = 1'b1;
        end

        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel output flops
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    reset_seq_ch u_ch (
      .sys_clk (sys_clk),
      .p_rst_n (p_rst_n),
      .clr_i   (soft_clr),
      .rel_i   (rel[g]),
      .rst_n_o (sys_rst_n[g])
    );
  end

  assign rst_done = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq -- scoreboard bench for reset_seq
//
// The stimulus pushes the expected output transitions into per-DUT queues.
// Each entry holds an edge number and an output value, both hand-computed.
// A monitor on each DUT samples the outputs on the falling clock edge. When
// the {rst_done, sys_rst_n} value changes, the monitor pops one entry from the
// queue and compares the edge number and the value.
// -----------------------------------------------------------------------------
module tb_reset_seq;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       p_rst_n      = 1'b0;
  logic       p_rst1_n     = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] sys_rst_n;
  logic       rst_done;
  logic [0:0] sys_rst1_n;
  logic       rst_done1;

  reset_seq #(.CH_NUM(4), .FILTER_LEN(8), .STAGE_GAP(16)) u_dut (
    .sys_clk      (sys_clk),
    .p_rst_n      (p_rst_n),
    .soft_rst_req (soft_rst_req),
    .sys_rst_n    (sys_rst_n),
    .rst_done     (rst_done)
  );

  reset_seq #(.CH_NUM(1), .FILTER_LEN(1), .STAGE_GAP(1)) u_dut1 (
    .sys_clk      (sys_clk),
    .p_rst_n      (p_rst1_n),
    .soft_rst_req (1'b0),
    .sys_rst_n    (sys_rst1_n),
    .rst_done     (rst_done1)
  );

  // cyc is the number of rising edges seen so far.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] val; } ev_t;
  typedef struct { int cyc; logic [1:0] val; } ev1_t;
  ev_t  q0[$];
  ev1_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic push0(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c; e.val = v;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [1:0] v);
    ev1_t e;
    e.cyc = c; e.val = v;
    q1.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge sys_clk);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic [4:0] prev0 = 5'b0;
  logic [4:0] cur0;
  ev_t        e0;
  always @(negedge sys_clk) begin
    cur0 = {rst_done, sys_rst_n};
    if (cur0 !== prev0) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL ch4_unexpected cyc=%0d got=%b", cyc, cur0);
      end else begin
        e0 = q0.pop_front();
        if (e0.cyc != cyc || e0.val !== cur0) begin
          n_err++;
          $display("FAIL ch4_event got cyc=%0d val=%b want cyc=%0d val=%b",
                   cyc, cur0, e0.cyc, e0.val);
        end
      end
      prev0 = cur0;
    end
  end

  logic [1:0] prev1 = 2'b0;
  logic [1:0] cur1;
  ev1_t       e1;
  always @(negedge sys_clk) begin
    cur1 = {rst_done1, sys_rst1_n};
    if (cur1 !== prev1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL ch1_unexpected cyc=%0d got=%b", cyc, cur1);
      end else begin
        e1 = q1.pop_front();
        if (e1.cyc != cyc || e1.val !== cur1) begin
          n_err++;
          $display("FAIL ch1_event got cyc=%0d val=%b want cyc=%0d val=%b",
                   cyc, cur1, e1.cyc, e1.val);
        end
      end
      prev1 = cur1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0, t1, s, x;

    // Reset state while both port resets are held low.
    wait_edge(2);
    chk("reset_rst_n",  {28'd0, sys_rst_n}, 32'h0);
    chk("reset_done",   {31'd0, rst_done},  32'h0);
    chk("reset_rst1_n", {31'd0, sys_rst1_n}, 32'h0);
    chk("reset_done1",  {31'd0, rst_done1}, 32'h0);

    // Power-up. p_rst_n rises after edge 3, so sync flop 1 captures high at
    // edge 4, which makes T0 = 4.
    t0 = 4;
    push0(t0 + 9,  5'b0_0001);
    push0(t0 + 25, 5'b0_0011);
    wait_edge(3);
    p_rst_n = 1'b1;

    // Single-channel DUT with lengths 1/1/1: T0 = 6, and bit 0 and done rise
    // together at edge 8.
    push1(8, 2'b11);
    wait_edge(5);
    p_rst1_n = 1'b1;

    // 2 ns glitch just after edge T0+30. The outputs clear asynchronously.
    // The new T0 is edge T0+31.
    wait_edge(t0 + 29);
    push0(t0 + 30, 5'b0_0000);
    @(posedge sys_clk);
    #2 p_rst_n = 1'b0;
    #1;
    chk("glitch_rst_n", {28'd0, sys_rst_n}, 32'h0);
    chk("glitch_done",  {31'd0, rst_done},  32'h0);
    #1 p_rst_n = 1'b1;

    t1 = t0 + 31;
    push0(t1 + 9,  5'b0_0001);
    push0(t1 + 25, 5'b0_0011);
    push0(t1 + 41, 5'b0_0111);
    push0(t1 + 57, 5'b1_1111);
    drain(200);

`ifdef RESET_SEQ_SOFT_EN
    // One-cycle soft request sampled at edge s, while the DUT is in DONE.
    s = t1 + 63;
    push0(s,     5'b0_0000);
    push0(s + 8, 5'b0_0001);
    wait_edge(s - 1);
    soft_rst_req = 1'b1;
    wait_edge(s);
    soft_rst_req = 1'b0;

    // Soft request held for edges x..x+19 while the DUT is in STAGE.
    x = s + 12;
    push0(x,      5'b0_0000);
    push0(x + 27, 5'b0_0001);
    push0(x + 43, 5'b0_0011);
    push0(x + 59, 5'b0_0111);
    push0(x + 75, 5'b1_1111);
    wait_edge(x - 1);
    soft_rst_req = 1'b1;
    wait_edge(x + 10);
    chk("soft_hold_rst_n", {28'd0, sys_rst_n}, 32'h0);
    wait_edge(x + 19);
    soft_rst_req = 1'b0;
    drain(200);
    chk("soft_end_done", {31'd0, rst_done}, 32'h1);
`else
    // The soft request is ignored in this build. The outputs must stay fully
    // released, and the monitor flags any change as an unexpected event.
    s = t1 + 63;
    wait_edge(s - 1);
    soft_rst_req = 1'b1;
    wait_edge(s);
    soft_rst_req = 1'b0;
    wait_edge(s + 20);
    chk("soft_ignored_rst_n", {28'd0, sys_rst_n}, 32'hF);
    chk("soft_ignored_done",  {31'd0, rst_done},  32'h1);
`endif

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
